// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and controller state encoding for the register file port controller
package regfile_pkg;
    localparam int DATA_W = 20;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy mask of pending destinations with set/clear/flush and hazard detect
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              src1_mask,
    input  logic              src2_mask,
    input  logic [ADDR_W-1:0] dst,
    input  logic              dst_en,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic              clr_en,
    output logic [NREGS-1:0]  busy,
    output logic              hazard
);
    logic [NREGS-1:0] set_mask, clr_mask;
    assign set_mask = {{(NREGS-1){1'b0}}, set_en} << dst;
    assign clr_mask = {{(NREGS-1){1'b0}}, clr_en} << clr_idx;
    assign hazard = (busy[src1] & ~src1_mask) | (busy[src2] & ~src2_mask) | (dst_en & busy[dst]);
    // a new reservation wins over a writeback retiring a register that was not pending
    always_ff @(posedge clk or negedge reset)
        if (!reset) busy <= '0;
        else busy <= flush ? '0 : (busy & ~clr_mask) | set_mask;
endmodule

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: operand capture, writeback arbitration and hazard stalls (REGFILE_BYPASS_EN forwards writebacks)
module regfile_port_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_src1,
    input  logic [ADDR_W-1:0] req_src2,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic              req_dst_en,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              mem_wb_valid,
    output logic              mem_wb_ready,
    input  logic [ADDR_W-1:0] mem_wb_addr,
    input  logic [DATA_W-1:0] mem_wb_data,
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [ADDR_W-1:0] alu_wb_addr,
    input  logic [DATA_W-1:0] alu_wb_data,
    output logic [ADDR_W-1:0] rf_r1_select,
    output logic [ADDR_W-1:0] rf_r2_select,
    input  logic [DATA_W-1:0] rf_read1,
    input  logic [DATA_W-1:0] rf_read2,
    output logic              rf_w,
    output logic [ADDR_W-1:0] rf_w_select,
    output logic [DATA_W-1:0] rf_write,
    output logic [NREGS-1:0]  busy
);
    state_t state, state_d;
    logic hazard, accept, byp1, byp2;
    assign rf_r1_select = req_src1;
    assign rf_r2_select = req_src2;
    assign mem_wb_ready = 1'b1;
    assign alu_wb_ready = !mem_wb_valid;
    assign rf_w         = reset & (mem_wb_valid | alu_wb_valid);
    assign rf_w_select  = mem_wb_valid ? mem_wb_addr : alu_wb_addr;
    assign rf_write     = mem_wb_valid ? mem_wb_data : alu_wb_data;
`ifdef REGFILE_BYPASS_EN
    assign byp1 = rf_w && rf_w_select == req_src1;
    assign byp2 = rf_w && rf_w_select == req_src2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    assign req_ready = !flush && !hazard && (state == EMPTY || op_ready);
    assign accept    = req_valid && req_ready;
    assign op_valid  = state == FULL;
    regfile_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .src1      (req_src1),
        .src2      (req_src2),
        .src1_mask (byp1),
        .src2_mask (byp2),
        .dst       (req_dst),
        .dst_en    (req_dst_en),
        .set_en    (accept && req_dst_en),
        .clr_idx   (rf_w_select),
        .clr_en    (rf_w),
        .busy      (busy),
        .hazard    (hazard)
    );
    // operand holding state: flush drops, accept fills, consume without refill empties
    always_comb state_d = flush ? EMPTY : accept ? FULL : op_ready ? EMPTY : state;
    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= EMPTY;
        else state <= state_d;
    // operand capture; forwarded writeback data replaces the stale file read
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            op_a <= '0;
            op_b <= '0;
        end else if (accept) begin
            op_a <= byp1 ? rf_write : rf_read1;
            op_b <= byp2 ? rf_write : rf_read2;
        end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: table-driven directed check of regfile_port_ctrl with a behavioural register file
module tb_regfile_port_ctrl;
    import regfile_pkg::*;
    logic clk = 0, reset = 0, flush = 0;
    logic req_valid = 0, req_ready, req_dst_en = 0, op_valid, op_ready = 0;
    logic [ADDR_W-1:0] req_src1 = 0, req_src2 = 0, req_dst = 0;
    logic [DATA_W-1:0] op_a, op_b;
    logic mem_wb_valid = 0, mem_wb_ready, alu_wb_valid = 0, alu_wb_ready;
    logic [ADDR_W-1:0] mem_wb_addr = 0, alu_wb_addr = 0, rf_r1_select, rf_r2_select, rf_w_select;
    logic [DATA_W-1:0] mem_wb_data = 0, alu_wb_data = 0, rf_read1, rf_read2, rf_write;
    logic rf_w;
    logic [NREGS-1:0] busy;
    logic [DATA_W-1:0] rf [NREGS];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    regfile_port_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_src1(req_src1), .req_src2(req_src2),
        .req_dst(req_dst), .req_dst_en(req_dst_en),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .rf_r1_select(rf_r1_select), .rf_r2_select(rf_r2_select), .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_w(rf_w), .rf_w_select(rf_w_select), .rf_write(rf_write), .busy(busy)
    );

    assign rf_read1 = rf[rf_r1_select];
    assign rf_read2 = rf[rf_r2_select];

    // register file model: preload while in reset, clocked write otherwise
    always @(posedge clk)
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= (i == 3) ? 20'h12345 : 20'h10000 + DATA_W'(i);
        end else if (rf_w) rf[rf_w_select] <= rf_write;

    typedef struct {
        logic rv; int s1, s2, d; logic de, ordy, fl;
        logic mv; int ma; logic [19:0] md;
        logic av; int aa; logic [19:0] ad;
        logic e_rdy, e_w; int e_sel; logic [19:0] e_wd; logic e_ardy;
        logic e_ov; logic [19:0] e_a, e_b; logic [15:0] e_busy;
    } vec_t;
    vec_t v[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

`ifdef REGFILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    initial begin
        //                 rv s1 s2 d de or fl mv ma md        av aa ad        rdy w sel wd        ardy ov a         b         busy
        v.push_back('{1, 3, 3, 5, 1, 0, 0, 0, 0, 0,        0, 0, 0,        1,  0, 0, 0,        1,   1, 20'h12345, 20'h12345, 16'h0020});
        v.push_back('{1, 5, 1, 0, 0, 1, 0, 0, 0, 0,        1, 5, 20'hABCDE, BYP, 1, 5, 20'hABCDE, 1,   BYP, BYP ? 20'hABCDE : 20'h12345, BYP ? 20'h10001 : 20'h12345, 16'h0000});
        v.push_back('{1, 5, 1, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        !BYP, 0, 0, 0,      1,   1, 20'hABCDE, 20'h10001, 16'h0000});
        v.push_back('{0, 0, 0, 0, 0, 1, 0, 1, 2, 20'h22222, 1, 4, 20'h44444, 1,  1, 2, 20'h22222, 0,   0, 20'hABCDE, 20'h10001, 16'h0000});
        v.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0,        1, 4, 20'h44444, 1,  1, 4, 20'h44444, 1,   0, 20'hABCDE, 20'h10001, 16'h0000});
        v.push_back('{1, 2, 4, 7, 1, 0, 0, 0, 0, 0,        0, 0, 0,        1,  0, 0, 0,        1,   1, 20'h22222, 20'h44444, 16'h0080});
        v.push_back('{1, 0, 0, 8, 1, 0, 0, 0, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1,   1, 20'h22222, 20'h44444, 16'h0080});
        v.push_back('{1, 0, 0, 8, 1, 0, 0, 0, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1,   1, 20'h22222, 20'h44444, 16'h0080});
        v.push_back('{1, 0, 0, 8, 1, 0, 0, 0, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1,   1, 20'h22222, 20'h44444, 16'h0080});
        v.push_back('{1, 0, 0, 8, 1, 0, 1, 0, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1,   0, 20'h22222, 20'h44444, 16'h0000});
        v.push_back('{1, 0, 0, 7, 1, 0, 0, 0, 0, 0,        0, 0, 0,        1,  0, 0, 0,        1,   1, 20'h10000, 20'h10000, 16'h0080});
        v.push_back('{1, 1, 1, 7, 1, 1, 0, 0, 0, 0,        0, 0, 0,        0,  0, 0, 0,        1,   0, 20'h10000, 20'h10000, 16'h0080});
        v.push_back('{1, 1, 1, 7, 1, 1, 0, 1, 7, 20'h77777, 0, 0, 0,       0,  1, 7, 20'h77777, 0,   0, 20'h10000, 20'h10000, 16'h0000});
        v.push_back('{1, 1, 1, 7, 1, 1, 0, 0, 0, 0,        0, 0, 0,        1,  0, 0, 0,        1,   1, 20'h10001, 20'h10001, 16'h0080});
        v.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0,        1, 9, 20'h99999, 1,  1, 9, 20'h99999, 1,   0, 20'h10001, 20'h10001, 16'h0080});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_a", 32'(op_a), 0);
        chk("rst_rf_w", 32'(rf_w), 0);
        @(negedge clk);
        reset = 1;

        foreach (v[i]) begin
            @(negedge clk);
            req_valid = v[i].rv; req_src1 = ADDR_W'(v[i].s1); req_src2 = ADDR_W'(v[i].s2);
            req_dst = ADDR_W'(v[i].d); req_dst_en = v[i].de; op_ready = v[i].ordy; flush = v[i].fl;
            mem_wb_valid = v[i].mv; mem_wb_addr = ADDR_W'(v[i].ma); mem_wb_data = v[i].md;
            alu_wb_valid = v[i].av; alu_wb_addr = ADDR_W'(v[i].aa); alu_wb_data = v[i].ad;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(v[i].e_rdy));
            chk($sformatf("v%0d_rf_w", i), 32'(rf_w), 32'(v[i].e_w));
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_wb_ready), 32'(v[i].e_ardy));
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_wb_ready), 1);
            chk($sformatf("v%0d_r1_sel", i), 32'(rf_r1_select), 32'(v[i].s1));
            if (v[i].e_w) begin
                chk($sformatf("v%0d_w_sel", i), 32'(rf_w_select), 32'(v[i].e_sel));
                chk($sformatf("v%0d_w_data", i), 32'(rf_write), 32'(v[i].e_wd));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_op_valid", i), 32'(op_valid), 32'(v[i].e_ov));
            chk($sformatf("v%0d_op_a", i), 32'(op_a), 32'(v[i].e_a));
            chk($sformatf("v%0d_op_b", i), 32'(op_b), 32'(v[i].e_b));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v[i].e_busy));
        end

        @(negedge clk);
        req_valid = 1; req_src1 = 0; req_src2 = 1; req_dst = 10; req_dst_en = 1; op_ready = 0; flush = 0;
        mem_wb_valid = 0; alu_wb_valid = 0;
        @(posedge clk);
        #1;
        chk("pre_rst_op_valid", 32'(op_valid), 1);
        chk("pre_rst_busy", 32'(busy), 32'h0480);
        @(negedge clk);
        req_valid = 0; alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = 20'h33333;
        #1;
        chk("pre_rst_rf_w", 32'(rf_w), 1);
        #1;
        reset = 0;
        #1;
        chk("async_op_valid", 32'(op_valid), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_op_a", 32'(op_a), 0);
        chk("async_op_b", 32'(op_b), 0);
        chk("async_rf_w", 32'(rf_w), 0);
        alu_wb_valid = 0;
        @(negedge clk);
        reset = 1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
